// File: rtl/knn_nat_master_pkg.sv
// ============================================================================
// knn_nat_master_pkg : shared KNN constants and FSM state encoding
// Revision 1.0
// ============================================================================
`default_nettype none

package knn_nat_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  localparam int C_TIMEOUT_DEFAULT    = 255;
  localparam int C_FIFO_DEPTH_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/knn_cmd_fifo.sv
// ============================================================================
// knn_cmd_fifo : synchronous command FIFO with simultaneous push/pop
// Revision 1.0
// ============================================================================
`default_nettype none

module knn_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      wptr_d = (wptr_q == PW'(DEPTH-1)) ? '0 : wptr_q + PW'(1);
    end
    if (pop_ok) begin
      rptr_d = (rptr_q == PW'(DEPTH-1)) ? '0 : rptr_q + PW'(1);
    end
    // A push and pop in the same cycle leave occupancy unchanged.
    if (push_ok && !pop_ok) begin
      count_d = count_q + (PW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/knn_nat_master.sv
// ============================================================================
// knn_nat_master : queued native-bus master with request timeout
// Revision 1.0
// ============================================================================
`default_nettype none

module knn_nat_master
  import knn_nat_master_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = C_FIFO_DEPTH_DEFAULT,
  parameter int TIMEOUT    = C_TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int ENT_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q, state_d;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_address_q, m_address_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
  logic                wr_q, wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [ENT_W-1:0]    fifo_wdata, fifo_rdata;
  logic                head_write;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_wdata;
  logic [STRB_W-1:0]   head_wstrb;

  assign fifo_wdata = {cmd_write, cmd_addr, cmd_wdata, cmd_wstrb};
  assign {head_write, head_addr, head_wdata, head_wstrb} = fifo_rdata;

  knn_cmd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    m_address_d = m_address_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          m_valid_d   = 1'b1;
          m_address_d = head_addr;
          m_wdata_d   = head_wdata;
          m_wstrb_d   = head_write ? head_wstrb : '0;
          wr_d        = head_write;
          cnt_d       = '0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        // Completion wins over timeout when both land on the final cycle.
        if (m_ready) begin
          m_valid_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? '0 : m_rdata;
          rsp_err_d   = 1'b0;
          state_d     = ST_RSP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          m_valid_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RSP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        m_valid_d   = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      m_valid_q   <= 1'b0;
      m_address_q <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_valid_q   <= m_valid_d;
      m_address_q <= m_address_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign m_valid   = m_valid_q;
  assign m_address = m_address_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_knn_nat_master.sv
// ============================================================================
// tb_knn_nat_master : directed self-checking bench for knn_nat_master
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_knn_nat_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        m_valid;
  logic [5:0]  m_address;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        use_ovr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Slave read data: a fixed pattern tagged with the address, or an override word.
  assign m_rdata = use_ovr ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {26'd0, m_address});

  knn_nat_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .m_valid   (m_valid),
    .m_address (m_address),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_rdata   (m_rdata),
    .m_ready   (m_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  task automatic consume;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int  n;
    logic ok;
    logic [31:0] held;

    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; m_ready = 1'b0; rsp_ready = 1'b0; use_ovr = 1'b0;
    tick(); tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_m_fields", {m_address, m_wdata, m_wstrb}, 0);
    rst = 1'b1;
    tick();

    // Single write, m_ready one cycle after m_valid rises.
    offer(1'b1, 6'h03, 32'h0000_0005, 4'hF);
    tick();
    cmd_valid = 1'b0;
    chk("wr_latency_low", m_valid, 0);
    tick();
    chk("wr_m_valid_c1", m_valid, 1);
    chk("wr_fields_c1", {m_address, m_wdata, m_wstrb}, {6'h03, 32'h5, 4'hF});
    tick();
    chk("wr_m_valid_c2", m_valid, 1);
    chk("wr_fields_c2", {m_address, m_wdata, m_wstrb}, {6'h03, 32'h5, 4'hF});
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("wr_m_valid_drop", m_valid, 0);
    chk("wr_rsp", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, 32'h0, 1'b0});
    consume();
    chk("wr_idle", {rsp_valid, busy}, 0);

    // Read with m_ready three cycles late.
    use_ovr = 1'b1;
    offer(1'b0, 6'h10, 32'h1234_5678, 4'hF);
    tick();
    cmd_valid = 1'b0;
    tick();
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!(m_valid && m_wstrb == 4'h0 && m_address == 6'h10)) ok = 1'b0;
      tick();
    end
    chk("rd_hold_wstrb0", {ok, m_valid, m_wstrb}, {1'b1, 1'b1, 4'h0});
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("rd_rsp", {m_valid, rsp_valid, rsp_rdata, rsp_err}, {1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0});
    consume();
    use_ovr = 1'b0;

    // Five back-to-back reads with m_ready low: queue fills behind one in flight.
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!cmd_ready) ok = 1'b0;
      offer(1'b0, 6'(i + 1), 32'h0, 4'h0);
      tick();
    end
    chk("fill_ready_seen", ok, 1);
    offer(1'b0, 6'h3F, 32'h0, 4'h0);
    chk("full_cmd_ready", cmd_ready, 0);
    tick();
    cmd_valid = 1'b0;
    chk("full_still", cmd_ready, 0);
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!m_valid && n < 10) begin tick(); n++; end
      chk($sformatf("q%0d_req_seen", i), m_valid, 1);
      chk($sformatf("q%0d_addr", i), m_address, 6'(i + 1));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk($sformatf("q%0d_rsp", i), {rsp_valid, rsp_rdata, rsp_err},
          {1'b1, 32'hC0DE_0000 | 32'(i + 1), 1'b0});
      consume();
      chk($sformatf("q%0d_gap", i), m_valid, 0);
    end
    tick();
    chk("q_drained", {busy, cmd_ready, m_valid}, {1'b0, 1'b1, 1'b0});

    // Timeout: m_ready never asserted.
    offer(1'b0, 6'h07, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    n = 0;
    while (m_valid && n < 300) begin n++; tick(); end
    chk("to_len", n, 255);
    chk("to_rsp", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, 32'h0, 1'b1});
    consume();

    // Next command completes normally with m_ready in the rising cycle.
    offer(1'b1, 6'h09, 32'hAA, 4'h3);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("after_to_req", {m_valid, m_address, m_wstrb}, {1'b1, 6'h09, 4'h3});
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("after_to_rsp", {m_valid, rsp_valid, rsp_rdata, rsp_err}, {1'b0, 1'b1, 32'h0, 1'b0});
    consume();

    // m_ready on the very last allowed cycle counts as a completion.
    offer(1'b0, 6'h15, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    ok = 1'b1;
    for (int i = 0; i < 254; i++) begin
      if (!m_valid) ok = 1'b0;
      tick();
    end
    chk("edge_hold", {ok, m_valid}, 2'b11);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("edge_rsp", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, 32'hC0DE_0015, 1'b0});
    consume();

    // Response back-pressure with a second command queued.
    m_ready = 1'b1;
    offer(1'b0, 6'h11, 32'h0, 4'h0);
    tick();
    offer(1'b0, 6'h12, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_req_a", {m_valid, m_address}, {1'b1, 6'h11});
    tick();
    held = 32'hC0DE_0011;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (m_valid || !rsp_valid || rsp_rdata != held || rsp_err) ok = 1'b0;
      tick();
    end
    chk("bp_stall", ok, 1);
    consume();
    chk("bp_gap", m_valid, 0);
    tick();
    chk("bp_req_b", {m_valid, m_address}, {1'b1, 6'h12});
    tick();
    m_ready = 1'b0;
    chk("bp_rsp_b", {rsp_valid, rsp_rdata}, {1'b1, 32'hC0DE_0012});
    consume();

    // Reset mid-transaction with two commands still queued.
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 6'(i + 32), 32'h0, 4'hF);
      tick();
    end
    cmd_valid = 1'b0;
    chk("rst_mid_pre", m_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_async", m_valid, 0);
    chk("rst_mid_state", {busy, cmd_ready, rsp_valid}, {1'b0, 1'b1, 1'b0});
    tick();
    rst = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_valid || rsp_valid || busy || !cmd_ready) ok = 1'b0;
    end
    chk("rst_mid_after", ok, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/knn_nat_master.md
KNN_NAT_MASTER -- requirements
Module: knn_nat_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 6: native-bus address width.
REQ-002 SHALL have parameter DATA_W, default 32: native-bus data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of 2): command queue entries.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum REQ cycles to wait for m_ready.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command queue not full.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  byte strobes for writes.
- m_valid  out  1  native-bus request.
- m_address  out  ADDR_W  native-bus address.
- m_wdata  out  DATA_W  native-bus write data.
- m_wstrb  out  DATA_W/8  native-bus strobes; all 0 for reads.
- m_rdata  in  DATA_W  native-bus read data.
- m_ready  in  1  native-bus completion.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  captured read data; 0 for writes and timeouts.
- rsp_err  out  1  transaction timed out.
- busy  out  1  FSM not IDLE or queue non-empty.

Function
REQ-006 SHALL push the command into the FIFO on each clk edge where cmd_valid and cmd_ready are both 1; cmd_ready = !full.
REQ-007 SHALL implement a FSM with states IDLE, REQ, and RSP.
REQ-008 In IDLE with the FIFO non-empty, SHALL pop the head, register m_address/m_wdata/m_wstrb, and enter REQ; m_valid SHALL be 1 in the second cycle after the cmd handshake cycle when starting from empty and idle.
REQ-009 In REQ, SHALL hold m_valid=1 and m_address/m_wdata/m_wstrb stable until m_ready is sampled 1.
REQ-010 On m_ready=1, SHALL capture m_rdata (reads) or 0 (writes), set rsp_err=0, drop m_valid at the next edge, and enter RSP.
REQ-011 SHALL accept m_ready in the same cycle m_valid first rises, as well as any later cycle; m_ready while in IDLE or RSP SHALL be ignored.
REQ-012 SHALL count REQ cycles with a timeout counter of width clog2(TIMEOUT+1); after TIMEOUT cycles without m_ready, SHALL drop m_valid, set rsp_rdata=0 and rsp_err=1, and enter RSP.
REQ-013 If m_ready arrives in the same cycle the counter hits TIMEOUT, SHALL treat it as a normal completion (rsp_err=0).
REQ-014 In RSP, SHALL hold rsp_valid=1 and the response stable until rsp_ready=1, then return to IDLE.
REQ-015 SHALL issue no new request while in RSP; m_valid SHALL never be asserted for two transactions back-to-back without an intervening low cycle.
REQ-016 SHALL allow FIFO push and pop in the same cycle, with occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 SHALL hold cmd_ready=0 when the FIFO is full and drop the offered command; the handshake rule in REQ-006 guarantees no loss.

Reset
REQ-018 While rst=0, SHALL force: FSM=IDLE; FIFO empty; m_valid=0; m_address=0; m_wdata=0; m_wstrb=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0; cmd_ready=1; timeout counter=0.
REQ-019 Reset asserted mid-transaction SHALL drop m_valid asynchronously, discard queued and in-flight commands, and produce no response.

Structure
REQ-020 State encodings and default TIMEOUT/FIFO_DEPTH SHALL be defined as constants in the shared KNN include header.
REQ-021 The command queue SHALL be a separate sub-module, knn_cmd_fifo, with a synchronous FIFO of width 1+ADDR_W+DATA_W+DATA_W/8.

Verification
REQ-022 Write addr=0x03, wdata=0x0000_0005, wstrb=0xF, with m_ready returned 1 cycle after m_valid -> m_valid held 2 cycles with stable fields; rsp_valid=1, rsp_rdata=0, rsp_err=0.
REQ-023 Read addr=0x10 with m_rdata=0xDEAD_BEEF and m_ready 3 cycles late -> m_wstrb=0 throughout; rsp_rdata=0xDEAD_BEEF.
REQ-024 Push 5 commands with m_ready held low -> cmd_ready=0 after 4 queued plus 1 in flight; all 5 responses arrive in order once m_ready toggles.
REQ-025 m_ready never asserted, TIMEOUT=255 -> m_valid high exactly 255 cycles; rsp_err=1, rsp_rdata=0; next command proceeds normally.
REQ-026 rsp_ready held low for 10 cycles with a second command queued -> no m_valid until the response is consumed; response stays stable.
REQ-027 rst pulled low while m_valid=1 with 2 commands queued -> m_valid=0 immediately; after release, busy=0, cmd_ready=1, and no rsp_valid.
